// File: rtl/ble_cmd_auth.sv
// ble_cmd_auth: BLE command-link front end. An 8N1 UART receiver turns the
// serial RX stream into bytes, and an authorisation FSM combines the 'G'/'S'
// commands with rider presence to produce the power-up enable.
//
// Ports:
//   clk        in   system clock (50 MHz)
//   rst_n      in   synchronous active-low reset
//   RX         in   asynchronous serial input, idles high
//   rider_off  in   high when load cells report no rider
//   rx_data    out  [7:0] last byte received with a good stop bit
//   rdy        out  one-cycle pulse, rx_data just updated
//   frm_err    out  one-cycle pulse, stop bit sampled low
//   pwr_up     out  power-up authorisation for balance/motor path
//
// UART FSM
//   state    | meaning
//   IDLE     | line idle, waiting for rx_s low
//   START    | half-bit wait, confirm start bit still low
//   DATA     | sampling 8 data bits, LSB first
//   STOP     | sampling stop bit, then strobe rdy or frm_err
//
// Auth FSM
//   state    | meaning
//   OFF      | power down, waiting for GO_CMD
//   PWR1     | running with rider on
//   PWR2     | stop requested, waiting for rider to step off

module ble_cmd_auth #(
  parameter int         BAUD_CNT = 2604,
  parameter logic [7:0] GO_CMD   = 8'h47,
  parameter logic [7:0] STOP_CMD = 8'h53
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       rider_off,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err,
  output logic       pwr_up
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam logic [1:0] AU_OFF   = 2'd0;
  localparam logic [1:0] AU_PWR1  = 2'd1;
  localparam logic [1:0] AU_PWR2  = 2'd2;

  // The IDLE cycle that detects the low line already counts as the first
  // half-bit clock, so the half-bit load is one short of BAUD_CNT/2. This
  // puts the start sample BAUD_CNT/2 clocks after detection and the stop
  // sample BAUD_CNT/2 + 9*BAUD_CNT clocks after it.
  localparam logic [11:0] HALF_LOAD = 12'(BAUD_CNT / 2 - 1);
  localparam logic [11:0] BIT_LOAD  = 12'(BAUD_CNT - 1);

  logic        r_rx_meta;
  logic        r_rx_s;
  logic [1:0]  r_uart_st;
  logic [11:0] r_baud_cnt;
  logic [3:0]  r_bit_cnt;
  logic [7:0]  r_shreg;
  logic [7:0]  r_rx_data;
  logic        r_rdy;
  logic        r_frm_err;
  logic [1:0]  r_auth_st;
  logic        r_pwr_up;

  logic        w_baud_tc;
  logic        w_go;
  logic        w_stop;
  logic [1:0]  w_auth_nxt;

  assign w_baud_tc = (r_baud_cnt == 12'd0);

  // Two-flop synchroniser; resets to the idle-high line level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= RX;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_uart_st  <= ST_IDLE;
      r_baud_cnt <= 12'd0;
      r_bit_cnt  <= 4'd0;
      r_shreg    <= 8'h00;
      r_rx_data  <= 8'h00;
      r_rdy      <= 1'b0;
      r_frm_err  <= 1'b0;
    end else begin
      r_rdy     <= 1'b0;
      r_frm_err <= 1'b0;
      case (r_uart_st)
        ST_IDLE: begin
          if (!r_rx_s) begin
            r_baud_cnt <= HALF_LOAD;
            r_bit_cnt  <= 4'd0;
            r_uart_st  <= ST_START;
          end
        end
        ST_START: begin
          if (w_baud_tc) begin
            if (r_rx_s) begin
              r_uart_st <= ST_IDLE;
            end else begin
              r_baud_cnt <= BIT_LOAD;
              r_uart_st  <= ST_DATA;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt - 12'd1;
          end
        end
        ST_DATA: begin
          if (w_baud_tc) begin
            r_shreg    <= {r_rx_s, r_shreg[7:1]};
            r_bit_cnt  <= r_bit_cnt + 4'd1;
            r_baud_cnt <= BIT_LOAD;
            if (r_bit_cnt == 4'd7) begin
              r_uart_st <= ST_STOP;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt - 12'd1;
          end
        end
        ST_STOP: begin
          if (w_baud_tc) begin
            if (r_rx_s) begin
              r_rx_data <= r_shreg;
              r_rdy     <= 1'b1;
            end else begin
              r_frm_err <= 1'b1;
            end
            r_uart_st <= ST_IDLE;
          end else begin
            r_baud_cnt <= r_baud_cnt - 12'd1;
          end
        end
        default: r_uart_st <= ST_IDLE;
      endcase
    end
  end

  // Only good frames raise rdy, so a framing error can never reach here.
  assign w_go   = r_rdy && (r_rx_data == GO_CMD);
  assign w_stop = r_rdy && (r_rx_data == STOP_CMD);

  always_comb begin
    w_auth_nxt = r_auth_st;
    case (r_auth_st)
      AU_OFF: begin
        if (w_go) w_auth_nxt = AU_PWR1;
      end
      AU_PWR1: begin
        if (w_stop) w_auth_nxt = rider_off ? AU_OFF : AU_PWR2;
      end
      AU_PWR2: begin
        // Rider stepping off wins over a simultaneous 'G'.
        if (rider_off)  w_auth_nxt = AU_OFF;
        else if (w_go)  w_auth_nxt = AU_PWR1;
      end
      default: w_auth_nxt = AU_OFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_auth_st <= AU_OFF;
      r_pwr_up  <= 1'b0;
    end else begin
      r_auth_st <= w_auth_nxt;
      r_pwr_up  <= (w_auth_nxt != AU_OFF);
    end
  end

  assign rx_data = r_rx_data;
  assign rdy     = r_rdy;
  assign frm_err = r_frm_err;
  assign pwr_up  = r_pwr_up;

endmodule

// File: tb/tb_ble_cmd_auth.sv
module tb_ble_cmd_auth;

  localparam int         BAUD = 64;
  localparam logic [7:0] GO   = 8'h47;
  localparam logic [7:0] STOP = 8'h53;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       RX;
  logic       rider_off;
  logic [7:0] rx_data;
  logic       rdy;
  logic       frm_err;
  logic       pwr_up;

  always #5 clk = ~clk;

  ble_cmd_auth #(.BAUD_CNT(BAUD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .RX       (RX),
    .rider_off(rider_off),
    .rx_data  (rx_data),
    .rdy      (rdy),
    .frm_err  (frm_err),
    .pwr_up   (pwr_up)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  b;
    bit          good;
    int unsigned cyc_exp;
    bit          pwr_after;
  } exp_t;

  exp_t       sb[$];
  int         checks   = 0;
  int         failures = 0;
  bit         mon_en   = 0;
  bit         exp_pwr  = 0;
  logic [7:0] exp_rx   = 8'h00;
  int         st       = 0;   // reference auth state: 0 off, 1 running, 2 stop requested

  task automatic chk(string name, longint act, longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Reference model: command rules applied per accepted byte.
  function automatic void model_byte(logic [7:0] b, bit good);
    if (!good) return;
    case (st)
      0: if (b == GO) st = 1;
      1: if (b == STOP) st = rider_off ? 0 : 2;
      2: if (b == GO) st = 1;
      default: st = 0;
    endcase
  endfunction

  // Monitor: pops the scoreboard on every strobe and tracks steady outputs.
  exp_t e;
  always @(negedge clk) begin
    if (mon_en) begin
      if (rdy || frm_err) begin
        if (sb.size() == 0) begin
          chk("unexpected_strobe", {rdy, frm_err}, 0);
        end else begin
          e = sb.pop_front();
          chk("strobe_rdy", rdy, e.good);
          chk("strobe_frm_err", frm_err, !e.good);
          chk("strobe_cycle", cyc, e.cyc_exp);
          if (e.good) exp_rx = e.b;
          chk("strobe_rx_data", rx_data, exp_rx);
          chk("pwr_up_at_strobe", pwr_up, exp_pwr);
          exp_pwr = e.pwr_after;
        end
      end else begin
        chk("rx_data_hold", rx_data, exp_rx);
        chk("pwr_up", pwr_up, exp_pwr);
      end
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(logic [7:0] b, bit good);
    exp_t x;
    model_byte(b, good);
    x.b         = b;
    x.good      = good;
    // RX low after edge cyc; 2 sync flops, IDLE detect one edge later,
    // then half a bit plus 9 bits to the stop sample.
    x.cyc_exp   = cyc + 3 + BAUD / 2 + 9 * BAUD;
    x.pwr_after = (st != 0);
    sb.push_back(x);
    RX = 1'b0;
    tick(BAUD);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      tick(BAUD);
    end
    RX = good;
    tick(BAUD);
    RX = 1'b1;
  endtask

  task automatic set_rider(bit v);
    rider_off = v;
    if (st == 2 && v) st = 0;
    tick(1);
    exp_pwr = (st != 0);
  endtask

  task automatic abort_frame(logic [7:0] b, int nbits);
    RX = 1'b0;
    tick(BAUD);
    for (int i = 0; i < nbits; i++) begin
      RX = b[i];
      tick(BAUD);
    end
    tick(BAUD / 3);
    rst_n = 1'b0;
    RX    = 1'b1;
    tick(1);
    st      = 0;
    exp_pwr = 0;
    exp_rx  = 8'h00;
    sb.delete();
    rst_n = 1'b1;
  endtask

  initial begin
    #(90000 * 10);
    $display("FAIL watchdog actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    logic [7:0] b;
    bit         good;
    rst_n     = 1'b0;
    RX        = 1'b1;
    rider_off = 1'b0;
    tick(5);
    chk("reset_rx_data", rx_data, 8'h00);
    chk("reset_rdy", rdy, 0);
    chk("reset_frm_err", frm_err, 0);
    chk("reset_pwr_up", pwr_up, 0);
    rst_n  = 1'b1;
    mon_en = 1;
    tick(10000);

    send_frame(GO, 1);        tick(BAUD);
    send_frame(STOP, 1);      tick(BAUD);   // PWR2, still powered
    set_rider(1);             tick(BAUD);   // PWR2 -> OFF
    set_rider(0);
    send_frame(GO, 1);        tick(BAUD);
    send_frame(STOP, 1);      tick(BAUD);   // PWR2
    send_frame(GO, 1);        tick(BAUD);   // back to PWR1
    set_rider(1);             tick(3 * BAUD); // no effect from PWR1
    send_frame(STOP, 1);      tick(BAUD);   // rider off -> OFF
    set_rider(0);

    send_frame(GO, 0);        tick(2 * BAUD); // framing error, stays OFF
    send_frame(GO, 1);        tick(BAUD);
    send_frame(STOP, 0);      tick(2 * BAUD); // framing error, stays PWR1
    RX = 1'b0; tick(10); RX = 1'b1; tick(2 * BAUD); // false start

    send_frame(8'h55, 1);
    send_frame(8'hAA, 1);
    send_frame(GO, 1);        tick(BAUD);
    send_frame(STOP, 1);
    abort_frame(8'h47, 3);    tick(3 * BAUD);
    send_frame(GO, 1);        tick(BAUD);

    for (int n = 0; n < 45; n++) begin
      case ($urandom_range(0, 4))
        0: set_rider(1'($urandom_range(0, 1)));
        default: begin
          case ($urandom_range(0, 3))
            0:       b = GO;
            1:       b = STOP;
            default: b = 8'($urandom);
          endcase
          good = ($urandom_range(0, 9) != 0);
          send_frame(b, good);
          if (!good) tick(BAUD);
        end
      endcase
      tick($urandom_range(0, BAUD));
    end

    tick(2 * BAUD);
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
